// File: rtl/multiplier_unsigned_seq.sv
// Sequential unsigned shift-add multiplier: product = multiplicand * multiplier + addend.
// One bit is retired per cycle, so an operation takes exactly WIDTH RUN cycles.
module multiplier_unsigned_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     addend,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_step;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 accept, last;

  always_comb begin
    accept   = start && (state != RUN);
    last     = (state == RUN) && (cnt == LAST);
    // mcand is pre-shifted to the current bit position, mplier[0] is the current bit
    acc_step = mplier[0] ? acc + mcand : acc;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc    <= {{WIDTH{1'b0}}, addend};
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      mplier <= multiplier;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      // result registers only move on the final step, so they hold through RUN
      if (last) begin
        product <= acc_step;
        ovf     <= |acc_step[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule
